// File: rtl/hub75_pkg.sv
// Shared types and widths for the HUB75 frame-buffer arbiter and shift-out path.
package hub75_pkg;

    typedef enum logic {
        SW_IDLE,
        SW_PEND
    } hub75_swap_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RD,
        GNT_WR
    } hub75_grant_t;

    // Default colour depth and packed RGB word width used by the shift-out path
    localparam int HUB75_BPP    = 8;
    localparam int HUB75_RGB_W  = 3 * HUB75_BPP;

    // RGB word width for an arbitrary per-channel depth
    function automatic int rgb_width(input int bpp);
        return 3 * bpp;
    endfunction

endpackage

// File: rtl/hub75_starve_guard.sv
// Starvation guard: counts consecutive read grants while a host write waits
// and forces a write slot once max_rd_run_p reads have gone by.
module hub75_starve_guard #(
    parameter int max_rd_run_p = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_valid,
    input  logic rd_grant,
    input  logic wr_grant,
    output logic force_wr
);

    localparam int run_width_p = $clog2(max_rd_run_p + 1);
    localparam logic [run_width_p-1:0] run_max = run_width_p'(max_rd_run_p);

    logic [run_width_p-1:0] rd_run;

    // Read-run counter: cleared when no write waits or a write is granted, saturates at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_run <= '0;
        end else if (!wr_valid || wr_grant) begin
            rd_run <= '0;
        end else if (rd_grant && (rd_run != run_max)) begin
            rd_run <= rd_run + 1'b1;
        end
    end

    assign force_wr = wr_valid && (rd_run == run_max);

endmodule

// File: rtl/hub75_fb_arbiter.sv
// Frame-buffer RAM arbiter for the HUB75 display (reads have priority, host
// writes are guaranteed a slot by the starvation guard).
// Optional double buffering is enabled by defining HUB75_FB_DOUBLE_BUF_EN:
// writes then go to the back bank and banks swap only at frame boundaries.
module hub75_fb_arbiter
    import hub75_pkg::*;
#(
    parameter int hpixel_p     = 64,
    parameter int vpixel_p     = 64,
    parameter int bpp_p        = 8,
    parameter int max_rd_run_p = 8,
    localparam int addr_width_p = $clog2(hpixel_p * vpixel_p),
    localparam int word_width_p = rgb_width(bpp_p)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_rd_req,
    input  logic [addr_width_p-1:0] i_rd_addr,
    output logic                    o_rd_ready,
    output logic                    o_rd_valid,
    output logic [word_width_p-1:0] o_rd_data,
    input  logic                    i_wr_valid,
    input  logic [addr_width_p-1:0] i_wr_addr,
    input  logic [word_width_p-1:0] i_wr_data,
    output logic                    o_wr_ready,
    input  logic                    i_swap_req,
    input  logic                    i_frame_done,
    output logic                    o_swap_pending,
    output logic                    o_front_bank,
    output logic                    o_mem_en,
    output logic                    o_mem_we,
    output logic [addr_width_p:0]   o_mem_addr,
    output logic [word_width_p-1:0] o_mem_wdata,
    input  logic [word_width_p-1:0] i_mem_rdata
);

    hub75_grant_t grant;
    logic         force_wr;
    logic         front_bank;
    logic         wr_bank;

    hub75_starve_guard #(
        .max_rd_run_p (max_rd_run_p)
    ) u_starve_guard (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (i_wr_valid),
        .rd_grant (grant == GNT_RD),
        .wr_grant (grant == GNT_WR),
        .force_wr (force_wr)
    );

    // Per-cycle grant decision: display reads win unless the guard forces a write
    always_comb begin
        grant = GNT_NONE;
        if (i_rd_req && !force_wr) begin
            grant = GNT_RD;
        end else if (i_wr_valid) begin
            grant = GNT_WR;
        end
    end

    // Drive the RAM port and handshakes from the grant
    always_comb begin
        o_rd_ready  = 1'b0;
        o_wr_ready  = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (grant)
            GNT_RD: begin
                o_rd_ready = 1'b1;
                o_mem_en   = 1'b1;
                o_mem_addr = {front_bank, i_rd_addr};
            end
            GNT_WR: begin
                o_wr_ready  = 1'b1;
                o_mem_en    = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = {wr_bank, i_wr_addr};
                o_mem_wdata = i_wr_data;
            end
            default: ;
        endcase
    end

    // Read data is valid one cycle after a read grant (synchronous RAM latency)
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= (grant == GNT_RD);
        end
    end

    assign o_rd_data = i_mem_rdata;

`ifdef HUB75_FB_DOUBLE_BUF_EN
    hub75_swap_state_t state;
    hub75_swap_state_t state_nxt;
    logic              toggle;

    // Swap state and front-bank register; the new bank applies from the cycle after frame_done
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SW_IDLE;
            front_bank <= 1'b0;
        end else begin
            state <= state_nxt;
            if (toggle) begin
                front_bank <= ~front_bank;
            end
        end
    end

    // Next swap state: a request waits for frame end unless both arrive together
    always_comb begin
        state_nxt = state;
        case (state)
            SW_IDLE: if (i_swap_req && !i_frame_done) state_nxt = SW_PEND;
            SW_PEND: if (i_frame_done) state_nxt = SW_IDLE;
            default: state_nxt = SW_IDLE;
        endcase
    end

    // Swap outputs: toggle on frame end when a swap is pending or requested in that cycle
    always_comb begin
        toggle         = 1'b0;
        o_swap_pending = (state == SW_PEND);
        case (state)
            SW_IDLE: toggle = i_swap_req && i_frame_done;
            SW_PEND: toggle = i_frame_done;
            default: toggle = 1'b0;
        endcase
    end

    assign wr_bank = ~front_bank;
`else
    logic unused_swap_inputs;

    assign front_bank         = 1'b0;
    assign wr_bank            = 1'b0;
    assign o_swap_pending     = 1'b0;
    assign unused_swap_inputs = i_swap_req ^ i_frame_done;
`endif

    assign o_front_bank = front_bank;

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Self-checking bench for hub75_fb_arbiter with a RAM model and a read-data scoreboard.
// Double-buffer scenarios are exercised when HUB75_FB_DOUBLE_BUF_EN is defined.
module tb_hub75_fb_arbiter;

    localparam int AW = 12;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          swap_req;
    logic          frame_done;
    logic          swap_pending;
    logic          front_bank;
    logic          mem_en;
    logic          mem_we;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram    [0:(1<<(AW+1))-1];
    logic [DW-1:0] shadow [0:(1<<(AW+1))-1];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_word;
    logic          exp_front;
    int            checks = 0;
    int            passed = 0;

    hub75_fb_arbiter #(
        .hpixel_p     (64),
        .vpixel_p     (64),
        .bpp_p        (8),
        .max_rd_run_p (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rd_req       (rd_req),
        .i_rd_addr      (rd_addr),
        .o_rd_ready     (rd_ready),
        .o_rd_valid     (rd_valid),
        .o_rd_data      (rd_data),
        .i_wr_valid     (wr_valid),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .o_wr_ready     (wr_ready),
        .i_swap_req     (swap_req),
        .i_frame_done   (frame_done),
        .o_swap_pending (swap_pending),
        .o_front_bank   (front_bank),
        .o_mem_en       (mem_en),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM model with one cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(a * 24'h01F3A7 + 24'h135799);
    endfunction

    function automatic logic wr_bank_exp();
`ifdef HUB75_FB_DOUBLE_BUF_EN
        return ~exp_front;
`else
        return 1'b0;
`endif
    endfunction

    task automatic idle_inputs();
        rd_req     = 1'b0;
        rd_addr    = '0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        swap_req   = 1'b0;
        frame_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rd_valid, front_bank, swap_pending} !== 3'b000)
            $display("[TB] FAIL reset_regs: got %b expected 000", {rd_valid, front_bank, swap_pending});
        else passed++;
        checks++;
        if ({mem_en, rd_ready, wr_ready} !== 3'b000)
            $display("[TB] FAIL reset_comb: got %b expected 000", {mem_en, rd_ready, wr_ready});
        else passed++;
        rst = 1'b0;
        exp_front = 1'b0;
        sb.delete();
    endtask

    task automatic test_writes();
        logic [AW:0] ea;
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_addr  = AW'(a);
            wr_data  = pat(a);
            #1;
            ea = {wr_bank_exp(), AW'(a)};
            checks++;
            if ({wr_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, ea, pat(a)})
                $display("[TB] FAIL write_port a=%0d: got rdy=%b we=%b addr=%h data=%h expected addr=%h data=%h",
                         a, wr_ready, mem_we, mem_addr, mem_wdata, ea, pat(a));
            else passed++;
            shadow[ea] = pat(a);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reads();
        for (int a = 0; a < 65; a++) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== (sb.size() != 0))
                $display("[TB] FAIL rd_valid: got %b expected %b", rd_valid, sb.size() != 0);
            else passed++;
            if (sb.size() != 0) begin
                exp_word = sb.pop_front();
                checks++;
                if (rd_data !== exp_word) $display("[TB] FAIL rd_data: got %h expected %h", rd_data, exp_word);
                else passed++;
            end
            if (a == 64) break;
            rd_req  = 1'b1;
            rd_addr = AW'(a);
            #1;
            checks++;
            if ({rd_ready, mem_en, mem_we} !== 3'b110)
                $display("[TB] FAIL read_grant a=%0d: got %b expected 110", a, {rd_ready, mem_en, mem_we});
            else passed++;
            checks++;
            if (mem_addr !== {exp_front, AW'(a)} || mem_addr[AW] !== front_bank)
                $display("[TB] FAIL read_addr a=%0d: got %h expected %h", a, mem_addr, {exp_front, AW'(a)});
            else passed++;
            sb.push_back(shadow[{exp_front, AW'(a)}]);
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        logic exp_rd;
        for (int k = 0; k < 37; k++) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== (sb.size() != 0))
                $display("[TB] FAIL rd_valid_cont: got %b expected %b", rd_valid, sb.size() != 0);
            else passed++;
            if (sb.size() != 0) begin
                exp_word = sb.pop_front();
                checks++;
                if (rd_data !== exp_word) $display("[TB] FAIL rd_data_cont: got %h expected %h", rd_data, exp_word);
                else passed++;
            end
            if (k == 36) break;
            rd_req   = 1'b1;
            rd_addr  = AW'(k);
            wr_valid = 1'b1;
            wr_addr  = AW'(200 + k);
            wr_data  = pat(1000 + k);
            #1;
            exp_rd = ((k % 9) != 8);
            checks++;
            if ({rd_ready, wr_ready} !== {exp_rd, ~exp_rd})
                $display("[TB] FAIL contention k=%0d: got rd=%b wr=%b expected rd=%b wr=%b",
                         k, rd_ready, wr_ready, exp_rd, ~exp_rd);
            else passed++;
            if (exp_rd) sb.push_back(shadow[{exp_front, AW'(k)}]);
            else        shadow[{wr_bank_exp(), AW'(200 + k)}] = pat(1000 + k);
        end
        idle_inputs();
    endtask

`ifndef HUB75_FB_DOUBLE_BUF_EN
    task automatic test_single_buffer();
        @(negedge clk);
        swap_req   = 1'b1;
        frame_done = 1'b1;
        @(negedge clk);
        swap_req   = 1'b0;
        frame_done = 1'b0;
        checks++;
        if ({front_bank, swap_pending} !== 2'b00)
            $display("[TB] FAIL single_swap_same: got %b expected 00", {front_bank, swap_pending});
        else passed++;
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (swap_pending !== 1'b0) $display("[TB] FAIL single_pending: got %b expected 0", swap_pending);
        else passed++;
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        wr_valid   = 1'b1;
        wr_addr    = 12'hFFF;
        wr_data    = 24'h5A5A5A;
        #1;
        checks++;
        if ({front_bank, mem_we, mem_addr} !== {1'b0, 1'b1, 13'h0FFF})
            $display("[TB] FAIL single_bank: got front=%b we=%b addr=%h expected front=0 we=1 addr=0fff",
                     front_bank, mem_we, mem_addr);
        else passed++;
        shadow[13'h0FFF] = 24'h5A5A5A;
        @(negedge clk);
        idle_inputs();
    endtask
`else
    task automatic test_double_buffer();
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 12'd5;
        wr_data  = 24'hABCDEF;
        #1;
        checks++;
        if (mem_addr !== {~exp_front, 12'd5}) $display("[TB] FAIL back_write: got %h expected %h", mem_addr, {~exp_front, 12'd5});
        else passed++;
        shadow[{~exp_front, 12'd5}] = 24'hABCDEF;
        @(negedge clk);
        idle_inputs();
        swap_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            swap_req = 1'b0;
            checks++;
            if ({swap_pending, front_bank} !== {1'b1, exp_front})
                $display("[TB] FAIL pending i=%0d: got %b expected %b", i, {swap_pending, front_bank}, {1'b1, exp_front});
            else passed++;
        end
        frame_done = 1'b1;
        rd_req     = 1'b1;
        rd_addr    = 12'd5;
        #1;
        checks++;
        if (mem_addr !== {exp_front, 12'd5}) $display("[TB] FAIL old_bank_on_done: got %h expected %h", mem_addr, {exp_front, 12'd5});
        else passed++;
        @(negedge clk);
        frame_done = 1'b0;
        exp_front  = ~exp_front;
        checks++;
        if ({swap_pending, front_bank} !== {1'b0, exp_front})
            $display("[TB] FAIL swap_done: got %b expected %b", {swap_pending, front_bank}, {1'b0, exp_front});
        else passed++;
        #1;
        sb.push_back(shadow[{exp_front, 12'd5}]);
        @(negedge clk);
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1) $display("[TB] FAIL swap_rd_valid: got %b expected 1", rd_valid);
        else passed++;
        exp_word = sb.pop_front();
        checks++;
        if (rd_data !== 24'hABCDEF || exp_word !== 24'hABCDEF)
            $display("[TB] FAIL swap_rd_data: got %h expected %h", rd_data, 24'hABCDEF);
        else passed++;
    endtask

    task automatic test_swap_same_cycle();
        @(negedge clk);
        swap_req   = 1'b1;
        frame_done = 1'b1;
        #1;
        checks++;
        if (swap_pending !== 1'b0) $display("[TB] FAIL same_cycle_pending: got %b expected 0", swap_pending);
        else passed++;
        @(negedge clk);
        swap_req   = 1'b0;
        frame_done = 1'b0;
        exp_front  = ~exp_front;
        checks++;
        if ({swap_pending, front_bank} !== {1'b0, exp_front})
            $display("[TB] FAIL same_cycle_toggle: got %b expected %b", {swap_pending, front_bank}, {1'b0, exp_front});
        else passed++;
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        checks++;
        if ({swap_pending, front_bank} !== {1'b1, exp_front})
            $display("[TB] FAIL double_req: got %b expected %b", {swap_pending, front_bank}, {1'b1, exp_front});
        else passed++;
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        exp_front  = ~exp_front;
        @(negedge clk);
        checks++;
        if ({swap_pending, front_bank} !== {1'b0, exp_front})
            $display("[TB] FAIL single_toggle: got %b expected %b", {swap_pending, front_bank}, {1'b0, exp_front});
        else passed++;
    endtask
`endif

    task automatic test_reset_midop();
        @(negedge clk);
`ifdef HUB75_FB_DOUBLE_BUF_EN
        swap_req = 1'b1;
`endif
        rd_req  = 1'b1;
        rd_addr = 12'd3;
        sb.push_back(shadow[{exp_front, 12'd3}]);
        @(negedge clk);
        swap_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1) $display("[TB] FAIL pre_reset_valid: got %b expected 1", rd_valid);
        else passed++;
        exp_word = sb.pop_front();
        checks++;
        if (rd_data !== exp_word) $display("[TB] FAIL pre_reset_data: got %h expected %h", rd_data, exp_word);
        else passed++;
`ifdef HUB75_FB_DOUBLE_BUF_EN
        checks++;
        if (swap_pending !== 1'b1) $display("[TB] FAIL pre_reset_pending: got %b expected 1", swap_pending);
        else passed++;
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        exp_front = 1'b0;
        sb.delete();
        checks++;
        if ({front_bank, swap_pending, rd_valid} !== 3'b000)
            $display("[TB] FAIL reset_midop: got %b expected 000", {front_bank, swap_pending, rd_valid});
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < (1 << (AW + 1)); i++) begin
            ram[i]    = '0;
            shadow[i] = '0;
        end
        mem_rdata = '0;
        exp_front = 1'b0;
        test_reset();
        test_writes();
        test_reads();
        test_contention();
`ifdef HUB75_FB_DOUBLE_BUF_EN
        test_double_buffer();
        test_swap_same_cycle();
        test_reads();
`else
        test_single_buffer();
`endif
        test_reset_midop();
        test_reads();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
